branch_resolve_ctrl: RTL and testbench
======================================

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter BHT_ENTRIES, default 16, meaning the number of 2-bit branch history counters (power of 2, 4..256).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning the flush duration after a mispredict (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port br_valid, input, 1, meaning a branch request is present.
REQ-006 SHALL have port br_ready, output, 1, meaning the block can accept a request.
REQ-007 SHALL have port br_funct3, input, 3, meaning the branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-008 SHALL have ports br_rs1 and br_rs2, input, 32 each, meaning the operands.
REQ-009 SHALL have ports br_pc and br_imm, input, 32 each, meaning the branch PC and the sign-extended offset.
REQ-010 SHALL have port br_pred, input, 1, meaning the prediction fetch used for this branch.
REQ-011 SHALL have port fe_pc, input, 32, meaning the fetch PC for the prediction lookup.
REQ-012 SHALL have port fe_pred_taken, output, 1, meaning the combinational prediction for fe_pc.
REQ-013 SHALL have ports redirect_valid, output, 1 and redirect_pc, output, 32, meaning the fetch redirect.
REQ-014 SHALL have port flush, output, 1, meaning the younger pipeline stages are to be squashed.
REQ-015 SHALL have port illegal_br, output, 1, meaning a one-cycle pulse for an unsupported funct3.
REQ-016 SHALL have ports br_count and mispred_count, output, 16 each, meaning the resolved-branch and mispredict counters.

Function
REQ-017 SHALL implement an FSM with states IDLE, RESOLVE and FLUSH; br_ready SHALL be 1 only in IDLE.
REQ-018 SHALL accept a request when br_valid && br_ready at cycle N and register funct3, operands, pc, imm and pred; the FSM SHALL then move IDLE->RESOLVE.
REQ-019 SHALL compute taken in RESOLVE using signed compares for 100/101 and unsigned compares for 110/111.
REQ-020 SHALL treat funct3 010/011 as not-taken, pulse illegal_br in RESOLVE, and skip the BHT update for them.
REQ-021 SHALL declare a mispredict when taken != pred, and then assert redirect_valid for exactly cycle N+1 (RESOLVE).
REQ-022 SHALL set redirect_pc = pc+imm when taken and pc+4 when not taken, each computed modulo 2^32; redirect_pc SHALL be 0 whenever redirect_valid is 0.
REQ-023 SHALL, on a mispredict, assert flush for exactly FLUSH_CYCLES cycles starting at N+1.
REQ-024 SHALL transition RESOLVE->FLUSH when there is a mispredict and FLUSH_CYCLES>1; it SHALL go RESOLVE->IDLE otherwise.
REQ-025 SHALL leave FLUSH for IDLE once an internal down-counter expires.
REQ-026 SHALL, on a correct prediction, keep flush at 0 and return br_ready to 1 at N+2.
REQ-027 SHALL index the BHT with pc[log2(BHT_ENTRIES)+1:2].
REQ-028 SHALL update the BHT counter in RESOLVE as a 2-bit saturating counter: taken increments, saturating at 11; not-taken decrements, saturating at 00.
REQ-029 SHALL drive fe_pred_taken from bit 1 of the counter at the fe_pc index; on a same-cycle lookup and update of one entry, the lookup SHALL return the pre-update value.
REQ-030 SHALL increment br_count in every RESOLVE, and mispred_count on each mispredict, both wrapping 0xFFFF->0x0000.
REQ-031 SHALL ignore br_valid while br_ready is 0; no request is buffered.

Reset
REQ-032 SHALL, while rst_n=0 and asynchronously, force state IDLE and br_ready=1 (after release); redirect_valid, redirect_pc, flush, illegal_br, br_count and mispred_count SHALL be 0 and all BHT entries 01.
REQ-033 SHALL abort any in-flight RESOLVE or FLUSH on a mid-operation reset, deasserting flush and redirect_valid immediately.

Verification
REQ-034 SHALL verify: BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> cycle N+1 redirect_valid=1, redirect_pc=0x120, flush=1 for 2 cycles, br_ready=1 at N+3.
REQ-035 SHALL verify: BLT rs1=0xFFFFFFFF, rs2=1, pred=1 -> taken, no redirect, flush=0, br_ready=1 at N+2; BLTU with the same operands and pred=1 -> redirect_pc=pc+4.
REQ-036 SHALL verify: pc=0xFFFFFFFC, imm=8, taken, pred=0 -> redirect_pc=0x00000004.
REQ-037 SHALL verify: four taken branches at pc=0x40 from reset -> BHT entry 01->10->11->11; fe_pc=0x40 gives fe_pred_taken=0,1,1,1 sampled before each update.
REQ-038 SHALL verify: funct3=011 -> illegal_br pulse, not-taken, and the BHT unchanged.
REQ-039 SHALL verify: rst_n dropped during FLUSH -> flush=0 within the same cycle; after release, state IDLE, counters 0, BHT=01.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
// Branch request channel between the issue stage and the branch resolver.
// The issue side drives the operands and prediction; the resolver returns ready.
interface branch_resolve_ctrl_if;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_funct3;
  logic [31:0] br_rs1;
  logic [31:0] br_rs2;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        br_pred;

  modport master (
    output br_valid,
    output br_funct3,
    output br_rs1,
    output br_rs2,
    output br_pc,
    output br_imm,
    output br_pred,
    input  br_ready
  );

  modport slave (
    input  br_valid,
    input  br_funct3,
    input  br_rs1,
    input  br_rs2,
    input  br_pc,
    input  br_imm,
    input  br_pred,
    output br_ready
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolver: evaluates a conditional branch one cycle after acceptance,
// redirects fetch on a mispredict, squashes younger stages and trains a 2-bit BHT.
module branch_resolve_ctrl #(
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_ctrl_if.slave  br,
  input  logic [31:0]           fe_pc,
  output logic                  fe_pred_taken,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  output logic                  flush,
  output logic                  illegal_br,
  output logic [15:0]           br_count,
  output logic [15:0]           mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESOLVE,
    S_FLUSH
  } state_e;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
  } req_t;

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [15:0]      br_count_q, br_count_d;
  logic [15:0]      mispred_count_q, mispred_count_d;
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];

  logic             in_resolve;
  logic             taken;
  logic             illegal;
  logic             mispredict;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] fe_idx;
  logic [31:0]      target_pc;
  logic [31:0]      fallthrough_pc;
  logic             fe_pc_unused;

  assign in_resolve     = (state_q == S_RESOLVE);
  assign upd_idx        = req_q.pc[IDX_W+1:2];
  assign fe_idx         = fe_pc[IDX_W+1:2];
  assign fe_pc_unused   = ^{fe_pc[31:IDX_W+2], fe_pc[1:0]};
  assign target_pc      = req_q.pc + req_q.imm;
  assign fallthrough_pc = req_q.pc + 32'd4;

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign fe_pred_taken  = bht_q[fe_idx][1];

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (req_q.funct3)
      3'b000:  taken = (req_q.rs1 == req_q.rs2);
      3'b001:  taken = (req_q.rs1 != req_q.rs2);
      3'b100:  taken = ($signed(req_q.rs1) <  $signed(req_q.rs2));
      3'b101:  taken = ($signed(req_q.rs1) >= $signed(req_q.rs2));
      3'b110:  taken = (req_q.rs1 <  req_q.rs2);
      3'b111:  taken = (req_q.rs1 >= req_q.rs2);
      default: illegal = 1'b1;
    endcase
  end

  assign mispredict = (taken != req_q.pred);

  always_comb begin
    br.br_ready    = (state_q == S_IDLE);
    redirect_valid = in_resolve && mispredict;
    redirect_pc    = '0;
    if (redirect_valid) begin
      redirect_pc = taken ? target_pc : fallthrough_pc;
    end
    flush          = (in_resolve && mispredict) || (state_q == S_FLUSH);
    illegal_br     = in_resolve && illegal;
    br_count       = br_count_q;
    mispred_count  = mispred_count_q;
  end

  // Sequencing: RESOLVE itself is the first flush cycle, FLUSH covers the rest.
  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    flush_cnt_d     = flush_cnt_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;

    case (state_q)
      S_IDLE: begin
        if (br.br_valid) begin
          req_d.funct3 = br.br_funct3;
          req_d.rs1    = br.br_rs1;
          req_d.rs2    = br.br_rs2;
          req_d.pc     = br.br_pc;
          req_d.imm    = br.br_imm;
          req_d.pred   = br.br_pred;
          state_d      = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        br_count_d = br_count_q + 16'd1;
        if (mispredict) begin
          mispred_count_d = mispred_count_q + 16'd1;
        end
        if (mispredict && (FLUSH_CYCLES > 1)) begin
          state_d     = S_FLUSH;
          flush_cnt_d = 4'(FLUSH_CYCLES - 2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Unsupported encodings leave the history untouched.
  always_comb begin
    bht_d = bht_q;
    if (in_resolve && !illegal) begin
      if (taken && (bht_q[upd_idx] != 2'b11)) begin
        bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      end else if (!taken && (bht_q[upd_idx] != 2'b00)) begin
        bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      req_q           <= '0;
      flush_cnt_q     <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      flush_cnt_q     <= flush_cnt_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // NOTE: the history table is built from flops, not RAM, so it can carry a reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed and randomized checks of branch_resolve_ctrl against a behavioural
// model of branch outcome, redirect target, flush length and BHT training.
module tb_branch_resolve_ctrl;
  localparam int ENTRIES = 16;
  localparam int FC      = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fe_pc;
  logic        fe_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        illegal_br;
  logic [15:0] br_count;
  logic [15:0] mispred_count;

  always #5 clk = ~clk;

  branch_resolve_ctrl_if bif ();

  branch_resolve_ctrl #(
    .BHT_ENTRIES (ENTRIES),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .br            (bif),
    .fe_pc         (fe_pc),
    .fe_pred_taken (fe_pred_taken),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .illegal_br    (illegal_br),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: counter values as integers 0..3, event counts as integers.
  int bht_m [ENTRIES];
  int cnt_m;
  int mis_m;
  bit last_mis;
  int last_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) bht_m[i] = 1;
    cnt_m = 0;
    mis_m = 0;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'b000:  return ua == ub;
      3'b001:  return ua != ub;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return ua < ub;
      3'b111:  return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic scramble_bus();
    bif.br_valid  = 1'($urandom_range(0, 1));
    bif.br_funct3 = 3'($urandom);
    bif.br_rs1    = $urandom;
    bif.br_rs2    = $urandom;
    bif.br_pc     = $urandom;
    bif.br_imm    = $urandom;
    bif.br_pred   = 1'($urandom_range(0, 1));
  endtask

  // Presents one branch, leaves the bench at the falling edge of cycle N+1.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    bit          tk, ill;
    logic [31:0] exp_pc;
    int          waited = 0;
    while (bif.br_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_issue", 32'(bif.br_ready), 32'd1);
    ill      = (f3 == 3'b010) || (f3 == 3'b011);
    tk       = model_taken(f3, a, b);
    last_idx = idx_of(pc);
    fe_pc         = pc;
    bif.br_valid  = 1'b1;
    bif.br_funct3 = f3;
    bif.br_rs1    = a;
    bif.br_rs2    = b;
    bif.br_pc     = pc;
    bif.br_imm    = imm;
    bif.br_pred   = pred;
    #1 check("fe_pred_before_accept", 32'(fe_pred_taken), 32'(bht_m[last_idx] >= 2));
    @(posedge clk);
    #1 scramble_bus();
    @(negedge clk);
    last_mis = (tk != pred);
    exp_pc   = last_mis ? (tk ? pc + imm : pc + 32'd4) : 32'd0;
    check("resolve_ready",    32'(bif.br_ready),   32'd0);
    check("redirect_valid",   32'(redirect_valid), 32'(last_mis));
    check("redirect_pc",      redirect_pc,         exp_pc);
    check("flush_resolve",    32'(flush),          32'(last_mis));
    check("illegal_br",       32'(illegal_br),     32'(ill));
    check("fe_pred_same_cyc", 32'(fe_pred_taken),  32'(bht_m[last_idx] >= 2));
    cnt_m = (cnt_m + 1) % 65536;
    if (last_mis) mis_m = (mis_m + 1) % 65536;
    if (!ill) begin
      if (tk) bht_m[last_idx] = (bht_m[last_idx] == 3) ? 3 : bht_m[last_idx] + 1;
      else    bht_m[last_idx] = (bht_m[last_idx] == 0) ? 0 : bht_m[last_idx] - 1;
    end
  endtask

  // Walks the remaining busy cycles and the first ready cycle.
  task automatic finish_branch();
    int busy;
    busy = last_mis ? FC : 1;
    for (int k = 2; k <= busy; k++) begin
      @(negedge clk);
      check("flush_tail",      32'(flush),          32'd1);
      check("busy_ready",      32'(bif.br_ready),   32'd0);
      check("tail_redirect",   32'(redirect_valid), 32'd0);
    end
    @(negedge clk);
    bif.br_valid = 1'b0;
    check("ready_after",     32'(bif.br_ready),   32'd1);
    check("flush_after",     32'(flush),          32'd0);
    check("redirect_after",  32'(redirect_valid), 32'd0);
    check("redirect_pc_off", redirect_pc,         32'd0);
    check("illegal_after",   32'(illegal_br),     32'd0);
    check("br_count",        32'(br_count),       32'(cnt_m));
    check("mispred_count",   32'(mispred_count),  32'(mis_m));
    check("fe_pred_after",   32'(fe_pred_taken),  32'(bht_m[last_idx] >= 2));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bif.br_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic check_idle_reset_state(input string tag);
    check({tag, "_ready"},    32'(bif.br_ready),   32'd1);
    check({tag, "_redirect"}, 32'(redirect_valid), 32'd0);
    check({tag, "_rpc"},      redirect_pc,         32'd0);
    check({tag, "_flush"},    32'(flush),          32'd0);
    check({tag, "_illegal"},  32'(illegal_br),     32'd0);
    check({tag, "_brcnt"},    32'(br_count),       32'd0);
    check({tag, "_miscnt"},   32'(mispred_count),  32'd0);
    for (int i = 0; i < ENTRIES; i++) begin
      fe_pc = 32'(i) << 2;
      #1 check({tag, "_bht"}, 32'(fe_pred_taken), 32'd0);
    end
  endtask

  initial begin
    logic [3:0]  seq_exp;
    logic [2:0]  f3_tab [8];
    logic [2:0]  f3;
    logic [31:0] a, b, pc;

    rst_n         = 1'b0;
    fe_pc         = '0;
    bif.br_valid  = 1'b0;
    bif.br_funct3 = '0;
    bif.br_rs1    = '0;
    bif.br_rs2    = '0;
    bif.br_pc     = '0;
    bif.br_imm    = '0;
    bif.br_pred   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("in_reset_flush",    32'(flush),          32'd0);
    check("in_reset_redirect", 32'(redirect_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_reset_state("reset");

    // BEQ equal with a not-taken prediction: redirect to the target, two flush cycles.
    issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    check("beq_target", redirect_pc, 32'h120);
    finish_branch();

    // Signed vs unsigned ordering of 0xFFFFFFFF against 1.
    issue(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1);
    check("blt_no_redirect", 32'(redirect_valid), 32'd0);
    finish_branch();
    issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1);
    check("bltu_fallthrough", redirect_pc, 32'h304);
    finish_branch();

    // Target wraps past the top of the address space.
    issue(3'b000, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'd8, 1'b0);
    check("wrap_target", redirect_pc, 32'h4);
    finish_branch();

    // Counter training from reset: 01 -> 10 -> 11 -> 11.
    do_reset();
    seq_exp = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      issue(3'b000, 32'd1, 32'd1, 32'h40, 32'h10, 1'b1);
      check("train_seq", 32'(fe_pred_taken), 32'(seq_exp[i]));
      finish_branch();
    end

    // Unsupported encodings: pulse, not-taken, no training.
    do_reset();
    issue(3'b000, 32'd3, 32'd3, 32'h84, 32'h0, 1'b1);
    finish_branch();
    issue(3'b011, 32'd3, 32'd3, 32'h84, 32'h10, 1'b1);
    check("illegal_pulse", 32'(illegal_br), 32'd1);
    check("illegal_rpc",   redirect_pc,     32'h88);
    finish_branch();
    check("illegal_bht_kept", 32'(fe_pred_taken), 32'd1);
    issue(3'b010, 32'd9, 32'd4, 32'h84, 32'h10, 1'b0);
    finish_branch();

    // Randomized branches.
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b100; f3_tab[3] = 3'b101;
    f3_tab[4] = 3'b110; f3_tab[5] = 3'b111; f3_tab[6] = 3'b010; f3_tab[7] = 3'b011;
    for (int n = 0; n < 60; n++) begin
      f3 = f3_tab[$urandom_range(0, 7)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc = $urandom & 32'hFFFF_FFFC;
      issue(f3, a, b, pc, $urandom, 1'($urandom_range(0, 1)));
      finish_branch();
    end

    // Reset while flushing.
    issue(3'b000, 32'd1, 32'd2, 32'h500, 32'h8, 1'b1);
    @(negedge clk);
    check("pre_reset_flush", 32'(flush), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_flush",    32'(flush),          32'd0);
    check("abort_redirect", 32'(redirect_valid), 32'd0);
    check("abort_ready",    32'(bif.br_ready),   32'd1);
    bif.br_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_idle_reset_state("post_abort");
    issue(3'b000, 32'd6, 32'd6, 32'h500, 32'h8, 1'b1);
    finish_branch();
    check("post_abort_bht_01", 32'(fe_pred_taken), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule
